nibble_add_seq: RTL
===================

Name: nibble_add_seq

Overview:
- Sequential multi-nibble add/subtract controller that reuses one 4-bit nibble-add slice over successive cycles.
- Computes a W-bit sum or difference one nibble per cycle, least-significant nibble first, rippling the carry through a register.
- Sits between an operand producer and a result consumer, each connected by its own valid/ready handshake.
- Handles one transaction at a time.

Parameters:
W, 8, operand width in bits; must be a multiple of 4 and at least 4; nibble count N = W/4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  operands a, b and op are valid.
in_ready  output  1  block can accept operands.
a  input  W  operand A.
b  input  W  operand B.
op  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  sum is valid.
out_ready  input  1  consumer accepts sum.
sum  output  W+1  result; bit W is carry-out (for subtract, 1 = no borrow).
busy  output  1  high in RUN or DONE.
nib_idx  output  ceil(log2 N), minimum 1  index of the nibble being processed (debug).

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Asserting rst forces IDLE immediately, regardless of clock.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - sum = 0; nib_idx = 0; carry register = 0; operand registers = 0.
- in_ready = (state == IDLE), decoded combinationally from the registered state. busy = (state != IDLE).
- States:
  - IDLE -> RUN on a clk edge with in_valid && in_ready.
    - Latch A = a.
    - Latch B = op ? ~b : b.
    - carry = op.
    - nib_idx = 0; clear result register.
  - RUN, one nibble per edge:
    - t = A[4i+3:4i] + B[4i+3:4i] + carry, a 5-bit value, with i = nib_idx.
    - result[4i+3:4i] = t[3:0]; carry = t[4]; nib_idx increments.
    - On the edge processing i = N-1: result[W] = t[4] and state -> DONE.
  - DONE: out_valid = 1; sum holds the full result.
    - On an edge with out_ready = 1: state -> IDLE, out_valid = 0, nib_idx = 0.
    - sum keeps its last value until the next accept.
- Latency and throughput:
  - out_valid rises exactly N edges after the accept edge (2 for W = 8).
  - With out_ready tied high, minimum spacing between accepts is N+2 cycles.
- Boundary conditions:
  - Input side: in_valid while busy is ignored; operands are not latched and no error is raised. a, b and op may change freely after the accept edge.
  - Output side: out_ready while not in DONE has no effect. If out_ready is held low, DONE persists indefinitely and sum and out_valid stay stable.
  - Reset mid-RUN or mid-DONE aborts the transaction; no out_valid is produced for it.
  - Arithmetic wraps modulo 2^W in sum[W-1:0]; sum[W] is the true carry-out.
  - Subtract is two's complement: A + ~B + 1.
  - No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-cycle -> immediately in_ready=1, out_valid=0, busy=0, sum=0, nib_idx=0.
- Add: op=0, a=8'h24, b=8'h81, out_ready=1 -> out_valid exactly 2 edges after accept; sum=9'h0A5.
- Carry chain:
  - a=8'h0D, b=8'h8D -> sum=9'h09A (nibble-0 carry propagates).
  - a=8'hFF, b=8'hFF -> sum=9'h1FE.
- Subtract:
  - op=1, a=8'h65, b=8'h12 -> sum=9'h153 (bit8=1, no borrow).
  - op=1, a=8'h12, b=8'h8F -> sum=9'h083 (bit8=0, borrow).
- Backpressure: out_ready=0 for 5 cycles after done -> out_valid and sum stable throughout.
  - A second in_valid with a=8'h01, b=8'h0D during this window is ignored.
  - Raise out_ready -> IDLE; then resubmit the same operands -> sum=9'h00E.
- Abort: pulse rst one cycle after accepting a=8'hF9, b=8'hC6 -> no out_valid.
  - A fresh transaction a=8'hC5, b=8'hAA then yields sum=9'h16F.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Multi-nibble add/subtract that reuses one 4-bit adder slice over N = W/4 cycles,
// least-significant nibble first, with valid/ready handshakes on both sides.
module nibble_add_seq #(
    parameter  int W  = 8,                          // multiple of 4, at least 4
    localparam int N  = W / 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    sum,
    output logic          busy,
    output logic [IW-1:0] nib_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic [W:0]    res_q;
    logic          out_valid_q;

    logic [3:0]    a_nib_d;
    logic [3:0]    b_nib_d;
    logic [4:0]    t_d;
    logic          last_nib_d;

    // Operand nibble select feeding the single shared 4-bit slice.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        a_nib_d = '0;
        b_nib_d = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib_d = a_q[i*4 +: 4];
                b_nib_d = b_q[i*4 +: 4];
            end
        end
        t_d        = {1'b0, a_nib_d} + {1'b0, b_nib_d} + {4'b0000, carry_q};
        last_nib_d = (idx_q == IW'(N - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract folds into the adder as A + ~B with carry-in 1.
                        a_q     <= a;
                        b_q     <= op ? ~b : b;
                        carry_q <= op;
                        idx_q   <= '0;
                        res_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx_q == IW'(i)) begin
                            res_q[i*4 +: 4] <= t_d[3:0];
                        end
                    end
                    carry_q <= t_d[4];
                    idx_q   <= idx_q + IW'(1);
                    if (last_nib_d) begin
                        res_q[W]    <= t_d[4];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = res_q;
    assign nib_idx   = idx_q;

endmodule
